// File: rtl/ps2_mouse_cursor_if.sv
// Byte stream from the PS/2 receiver into the cursor tracker.
interface ps2_mouse_cursor_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  modport master (output rx_data, output rx_valid, output rx_error);
  modport slave  (input  rx_data, input  rx_valid, input  rx_error);
endinterface

// File: rtl/ps2_mouse_cursor.sv
// Assembles PS/2 mouse packets, resynchronises on framing loss and tracks a
// clamped absolute cursor position with optional movement gain.
module ps2_mouse_cursor #(
  parameter int PKT_BYTES   = 3,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int GAIN_SHIFT  = 0,
  parameter int TIMEOUT_CYC = 1_250_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                recenter,
  ps2_mouse_cursor_if.slave   rx,
  output logic [X_W-1:0]      cursor_x,
  output logic [Y_W-1:0]      cursor_y,
  output logic [2:0]          buttons,
  output logic [3:0]          wheel,
  output logic                pkt_valid,
  output logic                sync_err
);

  localparam int MW = (X_W > Y_W) ? X_W : Y_W;
  localparam int AW = ((MW > 9) ? MW : 9) + GAIN_SHIFT + 2;
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0] B0 = 2'd0;
  localparam logic [1:0] B1 = 2'd1;
  localparam logic [1:0] B2 = 2'd2;
  localparam logic [1:0] B3 = 2'd3;

  localparam logic signed [AW-1:0] XMAX = AW'(SCREEN_W - 1);
  localparam logic signed [AW-1:0] YMAX = AW'(SCREEN_H - 1);
  localparam logic [X_W-1:0]       XC   = X_W'(SCREEN_W / 2);
  localparam logic [Y_W-1:0]       YC   = Y_W'(SCREEN_H / 2);

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf_x, r_ovf_y, r_sgn_x, r_sgn_y;
  logic [2:0]     r_btn;
  logic [7:0]     r_b1, r_b2;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [2:0]     r_buttons;
  logic [3:0]     r_wheel;
  logic           r_pkt, r_serr;

  logic                  w_last, w_tout;
  logic [7:0]            w_b2;
  logic [3:0]            w_wheel;
  logic signed [8:0]     w_dx9, w_dy9;
  logic signed [AW-1:0]  w_dx, w_dy, w_sx, w_sy, w_nx, w_ny;
  logic [X_W-1:0]        w_cx;
  logic [Y_W-1:0]        w_cy;

  // The final byte of a packet is decoded straight from rx_data.
  assign w_b2    = (PKT_BYTES == 3) ? rx.rx_data : r_b2;
  assign w_wheel = (PKT_BYTES == 4) ? rx.rx_data[3:0] : 4'h0;
  assign w_last  = enable && rx.rx_valid && !rx.rx_error &&
                   (((r_state == B2) && (PKT_BYTES == 3)) || (r_state == B3));
  assign w_tout  = (r_state != B0) && (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_dx9 = {r_sgn_x, r_b1};
    w_dy9 = {r_sgn_y, w_b2};
    w_dx  = r_ovf_x ? '0 : {{(AW-9){w_dx9[8]}}, w_dx9};
    w_dy  = r_ovf_y ? '0 : {{(AW-9){w_dy9[8]}}, w_dy9};
    w_sx  = w_dx <<< GAIN_SHIFT;
    w_sy  = w_dy <<< GAIN_SHIFT;
    w_nx  = $signed({{(AW-X_W){1'b0}}, r_x}) + w_sx;
    w_ny  = $signed({{(AW-Y_W){1'b0}}, r_y}) - w_sy;

    if (w_nx[AW-1])       w_cx = '0;
    else if (w_nx > XMAX) w_cx = X_W'(SCREEN_W - 1);
    else                  w_cx = w_nx[X_W-1:0];

    if (w_ny[AW-1])       w_cy = '0;
    else if (w_ny > YMAX) w_cy = Y_W'(SCREEN_H - 1);
    else                  w_cy = w_ny[Y_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= B0;
      r_cnt     <= '0;
      r_ovf_x   <= 1'b0;
      r_ovf_y   <= 1'b0;
      r_sgn_x   <= 1'b0;
      r_sgn_y   <= 1'b0;
      r_btn     <= '0;
      r_b1      <= '0;
      r_b2      <= '0;
      r_x       <= XC;
      r_y       <= YC;
      r_buttons <= '0;
      r_wheel   <= '0;
      r_pkt     <= 1'b0;
      r_serr    <= 1'b0;
    end else begin
      r_pkt  <= 1'b0;
      r_serr <= 1'b0;

      if (!enable) begin
        r_state <= B0;
        r_cnt   <= '0;
      end else if (rx.rx_error) begin
        r_state <= B0;
        r_cnt   <= '0;
        r_serr  <= 1'b1;
      end else if (rx.rx_valid) begin
        r_cnt <= '0;
        case (r_state)
          B0: begin
            if (rx.rx_data[3]) begin
              r_ovf_y <= rx.rx_data[7];
              r_ovf_x <= rx.rx_data[6];
              r_sgn_y <= rx.rx_data[5];
              r_sgn_x <= rx.rx_data[4];
              r_btn   <= rx.rx_data[2:0];
              r_state <= B1;
            end else begin
              r_serr  <= 1'b1;
            end
          end
          B1: begin
            r_b1    <= rx.rx_data;
            r_state <= B2;
          end
          B2: begin
            if (PKT_BYTES == 3) begin
              r_state <= B0;
            end else begin
              r_b2    <= rx.rx_data;
              r_state <= B3;
            end
          end
          default: r_state <= B0;
        endcase
      end else if (r_state != B0) begin
        if (w_tout) begin
          r_state <= B0;
          r_cnt   <= '0;
          r_serr  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      if (w_last) begin
        r_x       <= w_cx;
        r_y       <= w_cy;
        r_buttons <= r_btn;
        r_wheel   <= w_wheel;
        r_pkt     <= 1'b1;
      end

      // Recenter overrides any packet movement on the same edge.
      if (recenter) begin
        r_x <= XC;
        r_y <= YC;
      end
    end
  end

  assign cursor_x  = r_x;
  assign cursor_y  = r_y;
  assign buttons   = r_buttons;
  assign wheel     = r_wheel;
  assign pkt_valid = r_pkt;
  assign sync_err  = r_serr;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Drives one PS/2 byte stream into a 3-byte/gain-0 and a 4-byte/gain-2
// instance and scoreboards both against a packet-level reference model.
module tb_ps2_mouse_cursor;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst, enable, recenter;
  logic [9:0] xa, xb;
  logic [8:0] ya, yb;
  logic [2:0] ba, bb;
  logic [3:0] wa, wb;
  logic pva, pvb, sea, seb;

  ps2_mouse_cursor_if rx_if ();

  ps2_mouse_cursor #(.PKT_BYTES(3), .GAIN_SHIFT(0), .TIMEOUT_CYC(TO)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .recenter(recenter), .rx(rx_if.slave),
    .cursor_x(xa), .cursor_y(ya), .buttons(ba), .wheel(wa),
    .pkt_valid(pva), .sync_err(sea));

  ps2_mouse_cursor #(.PKT_BYTES(4), .GAIN_SHIFT(2), .TIMEOUT_CYC(TO)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .recenter(recenter), .rx(rx_if.slave),
    .cursor_x(xb), .cursor_y(yb), .buttons(bb), .wheel(wb),
    .pkt_valid(pvb), .sync_err(seb));

  always #5 clk = ~clk;

  typedef struct { int e; int x; int y; int b; int w; } pkt_t;
  pkt_t pq0[$], pq1[$];
  int   sq0[$], sq1[$];

  int tests = 0, fails = 0, cur_edge = 0;

  logic [7:0] d_data = 8'h00;
  logic d_valid = 1'b0, d_err = 1'b0, d_rec = 1'b0, d_en = 1'b1, d_rst = 1'b1;

  int mx[2], my[2], nb[2], last_e[2];
  logic [7:0] mb[2][4];

  function automatic int pb(input int i); return (i == 0) ? 3 : 4; endfunction
  function automatic int gs(input int i); return (i == 0) ? 0 : 2; endfunction
  function automatic int clampv(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_sync(input int i, input int e);
    if (i == 0) sq0.push_back(e); else sq1.push_back(e);
  endtask

  // Reference: what the upcoming clock edge e does to instance i.
  task automatic model(input int i, input int e);
    pkt_t p;
    int dx, dy;
    bit got;
    got = 0;
    if (d_rst) begin
      mx[i] = 320; my[i] = 240; nb[i] = 0;
      return;
    end
    if (!d_en) nb[i] = 0;
    else if (d_err) begin
      nb[i] = 0; push_sync(i, e);
    end else if (d_valid) begin
      if (nb[i] == 0 && !d_data[3]) push_sync(i, e);
      else begin
        mb[i][nb[i]] = d_data;
        nb[i]++;
        last_e[i] = e;
        if (nb[i] == pb(i)) begin
          dx = mb[i][0][4] ? int'(mb[i][1]) - 256 : int'(mb[i][1]);
          dy = mb[i][0][5] ? int'(mb[i][2]) - 256 : int'(mb[i][2]);
          if (mb[i][0][6]) dx = 0;
          if (mb[i][0][7]) dy = 0;
          mx[i] = clampv(mx[i] + dx * (1 << gs(i)), 639);
          my[i] = clampv(my[i] - dy * (1 << gs(i)), 479);
          p.b = int'(mb[i][0][2:0]);
          p.w = (pb(i) == 4) ? int'(mb[i][3][3:0]) : 0;
          nb[i] = 0;
          got = 1;
        end
      end
    end else if (nb[i] > 0 && (e - last_e[i]) == TO) begin
      nb[i] = 0; push_sync(i, e);
    end
    if (d_rec) begin mx[i] = 320; my[i] = 240; end
    if (got) begin
      p.e = e; p.x = mx[i]; p.y = my[i];
      if (i == 0) pq0.push_back(p); else pq1.push_back(p);
    end
  endtask

  task automatic chk(input int i, input logic pv, input logic se,
                     input int x, input int y, input int b, input int w);
    pkt_t p;
    int se_e;
    if (pv) begin
      tests++;
      if ((i == 0 && pq0.size() == 0) || (i == 1 && pq1.size() == 0)) begin
        fails++;
        $display("FAIL pkt%0d: unexpected pkt_valid at edge %0d", i, cur_edge);
      end else begin
        p = (i == 0) ? pq0.pop_front() : pq1.pop_front();
        if (p.e != cur_edge || p.x != x || p.y != y || p.b != b || p.w != w) begin
          fails++;
          $display("FAIL pkt%0d: got edge=%0d x=%0d y=%0d btn=%0d wh=%0d expected edge=%0d x=%0d y=%0d btn=%0d wh=%0d",
                   i, cur_edge, x, y, b, w, p.e, p.x, p.y, p.b, p.w);
        end
      end
    end
    if (se) begin
      tests++;
      if ((i == 0 && sq0.size() == 0) || (i == 1 && sq1.size() == 0)) begin
        fails++;
        $display("FAIL sync%0d: unexpected sync_err at edge %0d", i, cur_edge);
      end else begin
        se_e = (i == 0) ? sq0.pop_front() : sq1.pop_front();
        if (se_e != cur_edge) begin
          fails++;
          $display("FAIL sync%0d: got sync_err at edge %0d expected edge %0d", i, cur_edge, se_e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk(0, pva, sea, int'(xa), int'(ya), int'(ba), int'(wa));
    chk(1, pvb, seb, int'(xb), int'(yb), int'(bb), int'(wb));
  end

  task automatic drive(input logic [7:0] dt, input logic v, input logic er, input logic rc);
    d_data = dt; d_valid = v; d_err = er; d_rec = rc;
    rx_if.rx_data = dt; rx_if.rx_valid = v; rx_if.rx_error = er;
    recenter = rc; enable = d_en; rst = d_rst;
    model(0, cur_edge + 1);
    model(1, cur_edge + 1);
    @(posedge clk);
    cur_edge++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(a, 1'b1, 1'b0, 1'b0);
    drive(b, 1'b1, 1'b0, 1'b0);
    drive(c, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    d_rst = 1'b1;
    idle(3);
    d_rst = 1'b0;
    check("rst_xa", int'(xa), 320);
    check("rst_ya", int'(ya), 240);
    check("rst_ba", int'(ba), 0);
    check("rst_wa", int'(wa), 0);
    check("rst_xb", int'(xb), 320);
    check("rst_wb", int'(wb), 0);

    send3(8'h08, 8'h05, 8'h03);
    check("pkt1_xa", int'(xa), 325);
    check("pkt1_ya", int'(ya), 237);
    idle(110);

    drive(8'h00, 1'b0, 1'b0, 1'b1);
    send3(8'h19, 8'hF6, 8'h00);
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    check("neg_xa", int'(xa), 310);
    check("neg_ba", int'(ba), 1);
    check("gain_xb", int'(xb), 280);
    check("gain_yb", int'(yb), 240);

    send3(8'h08, 8'h01, 8'h01);
    check("resync_xa", int'(xa), 311);
    check("resync_ya", int'(ya), 239);
    idle(110);

    drive(8'h08, 1'b1, 1'b0, 1'b0);
    drive(8'h05, 1'b1, 1'b0, 1'b0);
    idle(110);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    send3(8'h08, 8'h02, 8'h00);
    check("tout_xa", int'(xa), 322);
    check("tout_ya", int'(ya), 240);
    idle(110);

    for (int k = 0; k < 3; k++) send3(8'h08, 8'hFF, 8'h00);
    check("clamp_xa", int'(xa), 639);
    for (int k = 0; k < 2; k++) send3(8'h08, 8'h00, 8'h7F);
    check("clamp_ya0", int'(ya), 0);
    send3(8'h28, 8'h00, 8'hFF);
    check("up1_ya", int'(ya), 1);
    send3(8'h08, 8'h00, 8'h05);
    check("clamp_ya1", int'(ya), 0);
    check("clamp_xa2", int'(xa), 639);
    idle(110);

    drive(8'h08, 1'b1, 1'b0, 1'b0);
    drive(8'h05, 1'b1, 1'b1, 1'b0);
    send3(8'h08, 8'h01, 8'h00);
    idle(110);

    drive(8'h00, 1'b0, 1'b0, 1'b1);
    send3(8'h48, 8'hFF, 8'h7F);
    drive(8'h0F, 1'b1, 1'b0, 1'b0);
    check("ovf_xb", int'(xb), 320);
    check("ovf_yb", int'(yb), 0);
    check("ovf_wb", int'(wb), 15);
    check("ovf_xa", int'(xa), 320);
    check("ovf_ya", int'(ya), 113);
    idle(110);

    drive(8'h08, 1'b1, 1'b0, 1'b0);
    drive(8'h05, 1'b1, 1'b0, 1'b0);
    drive(8'h03, 1'b1, 1'b0, 1'b1);
    check("rec_xa", int'(xa), 320);
    check("rec_ya", int'(ya), 240);
    idle(110);

    d_en = 1'b0;
    send3(8'h08, 8'h40, 8'h40);
    d_en = 1'b1;
    idle(2);
    check("dis_xa", int'(xa), 320);
    check("dis_ya", int'(ya), 240);
    drive(8'h08, 1'b1, 1'b0, 1'b0);
    d_en = 1'b0;
    drive(8'h05, 1'b1, 1'b0, 1'b1);
    d_en = 1'b1;
    drive(8'h03, 1'b1, 1'b0, 1'b0);
    idle(110);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      d_en = ($urandom_range(0, 49) != 0);
      if (r < 5) idle(105);
      else drive(8'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) == 0));
    end
    d_en = 1'b1;
    idle(110);

    check("pq0_left", pq0.size(), 0);
    check("pq1_left", pq1.size(), 0);
    check("sq0_left", sq0.size(), 0);
    check("sq1_left", sq1.size(), 0);
    check("end_xa", int'(xa), mx[0]);
    check("end_ya", int'(ya), my[0]);
    check("end_xb", int'(xb), mx[1]);
    check("end_yb", int'(yb), my[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
